// File: rtl/control_sequencer.sv
// Purpose: eight-phase instruction control sequencer; phase counter plus halted flag with decoded memory/datapath strobes.
// Latency: strobes are combinational from the current phase/opcode/zero/halt; phase and halt update on each clk rising edge.
// Backpressure: enab=0 freezes phase and halt (strobes keep decoding the held phase); halt=1 freezes phase until reset.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-low reset
//   enab    in   1  run enable
//   opcode  in   3  HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//   zero    in   1  accumulator-is-zero flag
//   step    in   1  single-step strobe (only when CTRL_SINGLE_STEP_EN is defined)
//   sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e  out 1  decoded strobes
//   halt    out  1  registered halted status
//   phase   out  3  current phase
//
// Build option: define CTRL_SINGLE_STEP_EN to add the step input; phase 0->1
// then advances only on an edge where step=1.

module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       enab,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t phase_q;
    phase_t phase_next;
    logic   halt_q;
    logic   halt_next;
    logic   aluop;
    logic   leave_inst_addr;

`ifdef CTRL_SINGLE_STEP_EN
    assign leave_inst_addr = step;
`else
    assign leave_inst_addr = 1'b1;
`endif

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= INST_ADDR;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_next;
            halt_q  <= halt_next;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        phase_next = phase_q;
        halt_next  = halt_q;
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        ld_ac      = 1'b0;
        wr         = 1'b0;
        data_e     = 1'b0;

        if (enab && !halt_q) begin
            if (phase_q == OP_ADDR && opcode == OP_HLT) begin
                // Halting parks the sequencer at OP_ADDR.
                halt_next = 1'b1;
            end else if (phase_q == INST_ADDR && !leave_inst_addr) begin
                phase_next = INST_ADDR;
            end else begin
                phase_next = phase_t'(phase_q + 3'd1);
            end
        end

        if (!halt_q) begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    // JMP raises load and increment together; the PC gives load priority.
                    inc_pc = (opcode == OP_JMP);
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign halt  = halt_q;
    assign phase = phase_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have no parameters; opcode width is fixed at 3 and phase width at 3.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low: acts only on a clk rising edge while low.
REQ-004 enab  input  1  run enable; low freezes phase and halted state.
REQ-005 opcode  input  3  instruction opcode from the instruction register (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7).
REQ-006 zero  input  1  accumulator-is-zero flag.
REQ-007 sel  output  1  memory address mux select; 1 = PC, 0 = IR operand.
REQ-008 rd  output  1  memory read strobe.
REQ-009 ld_ir  output  1  instruction register load.
REQ-010 inc_pc  output  1  program counter enab (increment).
REQ-011 ld_pc  output  1  program counter load (jump).
REQ-012 ld_ac  output  1  accumulator load.
REQ-013 wr  output  1  memory write strobe.
REQ-014 data_e  output  1  data bus drive enable.
REQ-015 halt  output  1  registered halted status.
REQ-016 phase  output  3  current phase register.

Function
REQ-017 Phase SHALL advance 0..7 and wrap 7->0 by one per clk while enab=1 and halt=0; otherwise it SHALL hold.
REQ-018 Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-019 Strobes SHALL be combinational decodes of phase, opcode, zero and halt; ALUOP means opcode in {ADD, AND, XOR, LDA}.
REQ-020 sel=1 in phases 0-3 only; rd=1 in phases 1-3, and in phases 5-7 when ALUOP.
REQ-021 ld_ir=1 in phases 2-3; inc_pc=1 in phase 4, in phase 6 when opcode=SKZ and zero=1, and in phase 7 when opcode=JMP.
REQ-022 ld_pc=1 in phases 6-7 when opcode=JMP; ld_ac=1 in phase 7 when ALUOP.
REQ-023 data_e=1 in phases 6-7 when opcode=STO; wr=1 in phase 7 when opcode=STO.
REQ-024 In phase 4 with opcode=HLT and enab=1, halt SHALL be set on that edge and phase SHALL stay at 4.
REQ-025 While halt=1 every strobe (sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e) SHALL be 0; only reset clears halt.
REQ-026 ld_pc and inc_pc both high in phase 7 (JMP) is legal; the downstream counter gives load priority.
REQ-027 With enab=0 the strobes SHALL still decode the held phase; the datapath gates its own writes.

Reset
REQ-028 On a clk edge with rst=0: phase=0 and halt=0, overriding enab, HLT and step; sel=1 and all other strobes 0 in the next cycle.
REQ-029 Reset mid-instruction SHALL abandon the instruction with no further wr, ld_ac or ld_pc pulse.

Configuration
REQ-030 Macro CTRL_SINGLE_STEP_EN defined: adds input step (1 bit); phase 0->1 occurs only on an edge with step=1; all other transitions unchanged.
REQ-031 Macro CTRL_SINGLE_STEP_EN undefined: no step port; phase 0->1 unconditional (subject to enab and halt).

Verification
REQ-032 rst=0 one edge, then rst=1, enab=1, opcode=ADD -> phase 0,1,...,7,0; rd high in phases 1-3 and 5-7; ld_ac high only in phase 7.
REQ-033 opcode=STO -> data_e in phases 6-7, wr only in phase 7, ld_ac never, rd low in phases 4-7.
REQ-034 opcode=SKZ: zero=1 -> inc_pc in phases 4 and 6; zero=0 -> inc_pc in phase 4 only.
REQ-035 opcode=HLT -> halt=1 after the phase-4 edge, phase stuck at 4, all strobes 0 for 20 cycles; rst=0 edge -> phase=0, halt=0.
REQ-036 opcode=JMP with enab dropped in phase 6 for 3 cycles -> phase holds at 6 with ld_pc=1; then phase 7 gives ld_pc=1 and inc_pc=1; with CTRL_SINGLE_STEP_EN, phase holds at 0 until step=1.
